imem_loader: RTL and testbench



---
 rtl/loader_pkg.sv | 18 +
 rtl/imem_loader_if.sv | 17 +
 rtl/loader_cksum.sv | 34 +++
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t           : loader FSM states (3-bit encoding)
//   IMEM_DEPTH        : instruction-memory depth; a length byte of 0 means this many bytes
//   DEFAULT_BASE_ADDR : first payload address and the core's PC reset target
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  localparam int unsigned IMEM_DEPTH        = 256;
  localparam logic [7:0]  DEFAULT_BASE_ADDR = 8'h00;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
//   in_data  : stream byte
//   in_valid : in_data valid this cycle
//   in_ready : sink can accept; a transfer happens when in_valid && in_ready at posedge
// master = stream source, slave = loader.
interface imem_loader_if #(
  parameter int unsigned DATA_W = 8
);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/loader_cksum.sv
// Mod-2^W running-sum accumulator with compare, used to verify a loaded image.
//   clk, reset : clock and synchronous active-high reset (sum -> 0)
//   i_clr      : clear sum to 0
//   i_init     : load sum with i_data (first byte of an image)
//   i_add      : sum += i_data (wraps)
//   i_data     : byte to accumulate / compare
//   o_match    : i_data equals the current sum
module loader_cksum #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_init,
  input  logic         i_add,
  input  logic [W-1:0] i_data,
  output logic         o_match
);

  logic [W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_sum <= '0;
    end else if (i_init) begin
      r_sum <= i_data;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_match = (i_data == r_sum);

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: receives length, payload and checksum bytes on a
// valid/ready stream, writes the payload into instruction memory, and holds the
// core in reset until the image verifies.
//   clk, reset : clock and synchronous active-high reset (back to IDLE)
//   s_in       : byte stream (in_data/in_valid in, in_ready out)
//   restart    : pulse; from RUN/ERROR returns to IDLE
//   mem_we/mem_addr/mem_wdata : registered instruction-memory write port
//   core_reset : core reset, low only in RUN
//   done       : high in RUN
//   err        : high in ERROR (checksum mismatch)
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 8,
  parameter int unsigned          DATA_W    = 8,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter bit                   CHECK_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  imem_loader_if.slave      s_in,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err
);

  // One extra bit so a length byte of 0 can stand for a full memory image.
  localparam int unsigned LEN_W = DATA_W + 1;

  state_t              r_state, w_next;
  logic [LEN_W-1:0]    r_len, r_count;
  logic [ADDR_W-1:0]   r_next_addr;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic w_in_ready, w_xfer, w_last, w_match;
  logic w_ck_clr, w_ck_init, w_ck_add;

  assign w_in_ready = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign w_xfer     = s_in.in_valid && w_in_ready;
  assign w_last     = (r_count + LEN_W'(1)) == r_len;

  assign s_in.in_ready = w_in_ready;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

  loader_cksum #(.W(DATA_W)) u_cksum (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_ck_clr),
    .i_init  (w_ck_init),
    .i_add   (w_ck_add),
    .i_data  (s_in.in_data),
    .o_match (w_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ck_clr   = 1'b0;
    w_ck_init  = 1'b0;
    w_ck_add   = 1'b0;
    core_reset = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_xfer) begin
          w_ck_init = 1'b1;
          w_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_xfer) begin
          w_ck_add = 1'b1;
          if (w_last) w_next = CHECK_EN ? ST_CHECK : ST_RUN;
        end
      end
      ST_CHECK: begin
        if (w_xfer) w_next = w_match ? ST_RUN : ST_ERROR;
      end
      ST_RUN: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (restart) begin
          w_ck_clr = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      ST_ERROR: begin
        err = 1'b1;
        if (restart) begin
          w_ck_clr = 1'b1;
          w_next   = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Write port and byte counting. mem_we defaults low every cycle so each
  // accepted payload byte yields exactly one write pulse; reset squashes any
  // write that was about to be issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len       <= '0;
      r_count     <= '0;
      r_next_addr <= BASE_ADDR;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_len       <= (s_in.in_data == '0) ? LEN_W'(IMEM_DEPTH) : LEN_W'(s_in.in_data);
            r_count     <= '0;
            r_next_addr <= BASE_ADDR;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_next_addr;
            r_mem_wdata <= s_in.in_data;
            r_next_addr <= r_next_addr + ADDR_W'(1);
            r_count     <= r_count + LEN_W'(1);
          end
        end
        ST_RUN, ST_ERROR: begin
          if (restart) r_count <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Three configurations: [0] base 00 with checksum, [1] base 80 with checksum,
  // [2] base 00 without checksum. Stimulus is steered to the selected one.
  int unsigned sel = 0;
  logic        t_valid = 1'b0;
  logic        t_restart = 1'b0;
  logic [7:0]  t_data = 8'h00;

  logic [7:0] bases [3] = '{8'h00, 8'h80, 8'h00};
  bit         ckens [3] = '{1'b1, 1'b1, 1'b0};

  imem_loader_if #(.DATA_W(8)) if0 ();
  imem_loader_if #(.DATA_W(8)) if1 ();
  imem_loader_if #(.DATA_W(8)) if2 ();

  assign if0.in_data  = t_data;
  assign if1.in_data  = t_data;
  assign if2.in_data  = t_data;
  assign if0.in_valid = t_valid && (sel == 0);
  assign if1.in_valid = t_valid && (sel == 1);
  assign if2.in_valid = t_valid && (sel == 2);

  logic [2:0] rs_v, we_v, cr_v, dn_v, er_v;
  logic [7:0] addr_v [3];
  logic [7:0] wd_v [3];

  assign rs_v[0] = t_restart && (sel == 0);
  assign rs_v[1] = t_restart && (sel == 1);
  assign rs_v[2] = t_restart && (sel == 2);

  imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00), .CHECK_EN(1'b1)) u0 (
    .clk(clk), .reset(reset), .s_in(if0), .restart(rs_v[0]),
    .mem_we(we_v[0]), .mem_addr(addr_v[0]), .mem_wdata(wd_v[0]),
    .core_reset(cr_v[0]), .done(dn_v[0]), .err(er_v[0]));

  imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h80), .CHECK_EN(1'b1)) u1 (
    .clk(clk), .reset(reset), .s_in(if1), .restart(rs_v[1]),
    .mem_we(we_v[1]), .mem_addr(addr_v[1]), .mem_wdata(wd_v[1]),
    .core_reset(cr_v[1]), .done(dn_v[1]), .err(er_v[1]));

  imem_loader #(.ADDR_W(8), .DATA_W(8), .BASE_ADDR(8'h00), .CHECK_EN(1'b0)) u2 (
    .clk(clk), .reset(reset), .s_in(if2), .restart(rs_v[2]),
    .mem_we(we_v[2]), .mem_addr(addr_v[2]), .mem_wdata(wd_v[2]),
    .core_reset(cr_v[2]), .done(dn_v[2]), .err(er_v[2]));

  logic       m_ready, m_we, m_cr, m_done, m_err;
  logic [7:0] m_addr, m_wdata;

  always_comb begin
    m_ready = if0.in_ready;
    m_we = we_v[0]; m_cr = cr_v[0]; m_done = dn_v[0]; m_err = er_v[0];
    m_addr = addr_v[0]; m_wdata = wd_v[0];
    case (sel)
      1: begin
        m_ready = if1.in_ready;
        m_we = we_v[1]; m_cr = cr_v[1]; m_done = dn_v[1]; m_err = er_v[1];
        m_addr = addr_v[1]; m_wdata = wd_v[1];
      end
      2: begin
        m_ready = if2.in_ready;
        m_we = we_v[2]; m_cr = cr_v[2]; m_done = dn_v[2]; m_err = er_v[2];
        m_addr = addr_v[2]; m_wdata = wd_v[2];
      end
      default: ;
    endcase
  end

  // Write log: every cycle with mem_we high is one write to the instruction memory.
  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        wlog [$];
  logic [7:0] pl_q [$];

  always @(negedge clk) begin
    if (m_we === 1'b1) wlog.push_back('{m_addr, m_wdata});
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: checksum is the length byte plus all payload bytes, mod 256.
  function automatic logic [7:0] model_cks(input logic [7:0] len_b);
    logic [7:0] s = len_b;
    foreach (pl_q[i]) s = s + pl_q[i];
    return s;
  endfunction

  // Reference: payload byte i lands at base+i (mod 256), in order, once each.
  // Returns -1 if the log matches, else the first differing index.
  function automatic int first_bad_write(input logic [7:0] base);
    int n = (wlog.size() < pl_q.size()) ? wlog.size() : pl_q.size();
    for (int i = 0; i < n; i++) begin
      if (wlog[i].a !== 8'(base + 8'(i)) || wlog[i].d !== pl_q[i]) return i;
    end
    if (wlog.size() != pl_q.size()) return n;
    return -1;
  endfunction

  function automatic string wr_desc(input int idx, input logic [7:0] base);
    string got = "none";
    string exp = "none";
    if (idx < wlog.size()) got = $sformatf("%h@%h", wlog[idx].d, wlog[idx].a);
    if (idx < pl_q.size()) exp = $sformatf("%h@%h", pl_q[idx], 8'(base + 8'(idx)));
    return $sformatf("entry %0d got %s expected %s (logged %0d, expected %0d writes)",
                     idx, got, exp, wlog.size(), pl_q.size());
  endfunction

  // Entered and left at a negedge; one byte is transferred per call.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int unsigned tries = 0;
    if (stall) begin
      repeat ($urandom_range(0, 3)) begin
        t_valid   = 1'b0;
        t_data    = 8'($urandom);
        t_restart = ($urandom_range(0, 3) == 0);
        @(negedge clk);
      end
      t_restart = 1'b0;
    end
    t_valid = 1'b1;
    t_data  = b;
    while (!m_ready && tries < 8) begin
      @(negedge clk);
      tries++;
    end
    if (!m_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL handshake: in_ready=%b after %0d cycles, required 1", m_ready, tries);
      t_valid = 1'b0;
    end else begin
      @(negedge clk);
      t_valid = 1'b0;
    end
  endtask

  task automatic send_image(input logic [7:0] len_b, input bit stall);
    send_byte(len_b, stall);
    foreach (pl_q[i]) send_byte(pl_q[i], stall);
  endtask

  task automatic restart_pulse();
    t_restart = 1'b1;
    @(negedge clk);
    t_restart = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] got, exp;
    reset   = 1'b1;
    t_valid = 1'b1;
    t_data  = 8'hA5;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      got = {m_ready, m_we, m_addr, m_wdata, m_cr, m_done, m_err};
      exp = {1'b1, 1'b0, bases[s], 8'h00, 1'b1, 1'b0, 1'b0};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: {rdy,we,addr,wdata,crst,done,err} got %h required %h", s, got, exp);
      end
    end
    t_valid = 1'b0;
    sel = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_good_image();
    logic [3:0] exp;
    int bad;
    sel = 0;
    wlog.delete();
    pl_q = '{8'h41, 8'h82, 8'hC3};
    send_image(8'h03, 1'b0);
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL good.before_cks: {crst,done,err,rdy} got %b required 1001", {m_cr, m_done, m_err, m_ready});
    end
    send_byte(8'h89, 1'b0);
    exp = (model_cks(8'h03) == 8'h89) ? 4'b0100 : 4'b1010;
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== exp) begin
      n_fail++;
      $display("FAIL good.first_cycle: {crst,done,err,rdy} got %b required %b", {m_cr, m_done, m_err, m_ready}, exp);
    end
    repeat (2) @(negedge clk);
    #1;
    bad = first_bad_write(8'h00);
    n_tests++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL good.writes: %s", wr_desc(bad, 8'h00));
    end
    restart_pulse();
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL good.restart: {crst,done,err,rdy} got %b required 1001", {m_cr, m_done, m_err, m_ready});
    end
  endtask

  task automatic test_bad_checksum();
    logic [3:0] exp;
    int bad;
    sel = 0;
    wlog.delete();
    pl_q = '{8'h41, 8'h82, 8'hC3};
    send_image(8'h03, 1'b0);
    send_byte(8'h88, 1'b0);
    exp = (model_cks(8'h03) == 8'h88) ? 4'b0100 : 4'b1010;
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== exp) begin
      n_fail++;
      $display("FAIL bad.error_state: {crst,done,err,rdy} got %b required %b", {m_cr, m_done, m_err, m_ready}, exp);
    end
    // Bytes offered while not ready must be ignored.
    t_valid = 1'b1;
    t_data  = 8'h5A;
    repeat (3) @(negedge clk);
    t_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    bad = first_bad_write(8'h00);
    n_tests++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL bad.writes: %s", wr_desc(bad, 8'h00));
    end
    n_tests++;
    if ({m_cr, m_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL bad.hold: {crst,err} got %b required 11", {m_cr, m_err});
    end
    restart_pulse();
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL bad.restart: {crst,done,err,rdy} got %b required 1001", {m_cr, m_done, m_err, m_ready});
    end
  endtask

  task automatic test_stall_random();
    logic [7:0] len_b, cks;
    logic [3:0] exp;
    int unsigned n;
    int bad;
    bit good;
    sel = 0;
    for (int k = 0; k < 8; k++) begin
      wlog.delete();
      pl_q.delete();
      if (k == 0) begin
        pl_q  = '{8'h41, 8'h82, 8'hC3};
        len_b = 8'h03;
        cks   = 8'h89;
      end else begin
        n = $urandom_range(1, 24);
        for (int i = 0; i < int'(n); i++) pl_q.push_back(8'($urandom));
        len_b = 8'(n);
        good  = ($urandom_range(0, 1) == 1);
        cks   = good ? model_cks(len_b) : (model_cks(len_b) ^ (8'h01 << $urandom_range(0, 7)));
      end
      send_image(len_b, 1'b1);
      send_byte(cks, 1'b1);
      exp = (cks == model_cks(len_b)) ? 4'b0100 : 4'b1010;
      n_tests++;
      if ({m_cr, m_done, m_err, m_ready} !== exp) begin
        n_fail++;
        $display("FAIL stall[%0d].final: {crst,done,err,rdy} got %b required %b", k, {m_cr, m_done, m_err, m_ready}, exp);
      end
      repeat (2) @(negedge clk);
      #1;
      bad = first_bad_write(8'h00);
      n_tests++;
      if (bad != -1) begin
        n_fail++;
        $display("FAIL stall[%0d].writes: %s", k, wr_desc(bad, 8'h00));
      end
      restart_pulse();
    end
  endtask

  task automatic test_full_length();
    logic [3:0] exp;
    int bad;
    sel = 1;
    wlog.delete();
    pl_q.delete();
    for (int i = 0; i < 256; i++) pl_q.push_back(8'(i));
    send_image(8'h00, 1'b0);
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL full.before_cks: {crst,done,err,rdy} got %b required 1001", {m_cr, m_done, m_err, m_ready});
    end
    send_byte(8'h80, 1'b0);
    exp = (model_cks(8'h00) == 8'h80) ? 4'b0100 : 4'b1010;
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== exp) begin
      n_fail++;
      $display("FAIL full.final: {crst,done,err,rdy} got %b required %b", {m_cr, m_done, m_err, m_ready}, exp);
    end
    repeat (2) @(negedge clk);
    #1;
    bad = first_bad_write(8'h80);
    n_tests++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL full.writes: %s", wr_desc(bad, 8'h80));
    end
    restart_pulse();
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] cks;
    int bad;
    sel = 0;
    wlog.delete();
    pl_q.delete();
    for (int i = 0; i < 5; i++) pl_q.push_back(8'($urandom));
    send_byte(8'h05, 1'b0);
    send_byte(pl_q[0], 1'b0);
    send_byte(pl_q[1], 1'b0);
    // Third byte offered in the same cycle as reset: reset must win.
    t_valid = 1'b1;
    t_data  = pl_q[2];
    reset   = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if ({m_we, m_cr, m_done, m_err, m_ready} !== 5'b01001) begin
      n_fail++;
      $display("FAIL midreset.state: {we,crst,done,err,rdy} got %b required 01001", {m_we, m_cr, m_done, m_err, m_ready});
    end
    n_tests++;
    if (wlog.size() != 2 || wlog[1].a !== 8'h01 || wlog[1].d !== pl_q[1]) begin
      n_fail++;
      $display("FAIL midreset.writes: logged %0d writes, required 2 ending with %h@01", wlog.size(), pl_q[1]);
    end
    t_valid = 1'b0;
    reset   = 1'b0;
    @(negedge clk);
    wlog.delete();
    pl_q.delete();
    for (int i = 0; i < 4; i++) pl_q.push_back(8'($urandom));
    cks = model_cks(8'h04);
    send_image(8'h04, 1'b0);
    send_byte(cks, 1'b0);
    n_tests++;
    if ({m_cr, m_done, m_err} !== 3'b010) begin
      n_fail++;
      $display("FAIL midreset.reload: {crst,done,err} got %b required 010", {m_cr, m_done, m_err});
    end
    repeat (2) @(negedge clk);
    #1;
    bad = first_bad_write(8'h00);
    n_tests++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL midreset.reload_writes: %s", wr_desc(bad, 8'h00));
    end
    restart_pulse();
  endtask

  task automatic test_no_check();
    int bad;
    sel = 2;
    wlog.delete();
    pl_q = '{8'h10, 8'h20};
    send_image(8'h02, 1'b0);
    n_tests++;
    if ({m_cr, m_done, m_err, m_ready} !== 4'b0100) begin
      n_fail++;
      $display("FAIL nocheck.run: {crst,done,err,rdy} got %b required 0100", {m_cr, m_done, m_err, m_ready});
    end
    t_valid = 1'b1;
    t_data  = 8'h30;
    repeat (2) @(negedge clk);
    t_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    bad = first_bad_write(8'h00);
    n_tests++;
    if (bad != -1) begin
      n_fail++;
      $display("FAIL nocheck.writes: %s", wr_desc(bad, 8'h00));
    end
    n_tests++;
    if ({m_done, m_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL nocheck.hold: {done,rdy} got %b required 10", {m_done, m_ready});
    end
    restart_pulse();
  endtask

  initial begin
    test_reset();
    test_good_image();
    test_bad_checksum();
    test_stall_random();
    test_full_length();
    test_reset_mid_load();
    test_no_check();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
